// File: rtl/imem_loader.sv
// imem_loader: streams host instruction words into the 1024x32 instruction
// memory, reads the same range back, and compares write/read checksums while
// holding the CPU stalled.
//
// state  | meaning
// IDLE   | waiting for load_start; CPU released
// WRITE  | accepting host beats, one imem write per accepted beat
// VERIFY | issuing read addresses and accumulating read data
// FINISH | one-cycle done pulse with checksum result on pass
module imem_loader #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] load_base,
    input  logic [ADDR_W:0]   load_len,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              len_err
);

    localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, WRITE, VERIFY, FINISH} state_t;

    state_t             state, state_nxt;
    logic [ADDR_W-1:0]  base;
    logic [ADDR_W:0]    len;
    logic [ADDR_W:0]    wcnt;
    logic [ADDR_W:0]    icnt;
    logic [ADDR_W:0]    scnt;
    logic [DATA_W-1:0]  wsum;
    logic [DATA_W-1:0]  rsum;
    logic               rd_iss;
    logic               rd_smp;

    logic len_legal, start_ok, beat, write_last, issue, sample, read_last;

    // rd_iss marks that mem_addr currently holds a read address; rd_smp marks
    // that mem_rdata now carries the data for that address (one cycle later).
    assign len_legal  = (load_len != '0) && (load_len <= LEN_MAX);
    assign start_ok   = (state == IDLE) && load_start && len_legal;
    assign beat       = (state == WRITE) && wr_valid;
    assign write_last = beat && ((wcnt + 1'b1) == len);
    assign issue      = (state == VERIFY) && (icnt != len);
    assign sample     = (state == VERIFY) && rd_smp;
    assign read_last  = sample && ((scnt + 1'b1) == len);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_ok)   state_nxt = WRITE;
            WRITE:   if (write_last) state_nxt = VERIFY;
            VERIFY:  if (read_last)  state_nxt = FINISH;
            FINISH:                  state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        wr_ready = (state == WRITE);
        busy     = (state != IDLE);
        cpu_hold = (state != IDLE);
        done     = (state == FINISH);
    end

    // Datapath: latch request, drive imem port, accumulate checksums
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base      <= '0;
            len       <= '0;
            wcnt      <= '0;
            icnt      <= '0;
            scnt      <= '0;
            wsum      <= '0;
            rsum      <= '0;
            rd_iss    <= 1'b0;
            rd_smp    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            pass      <= 1'b0;
            len_err   <= 1'b0;
        end else begin
            len_err <= (state == IDLE) && load_start && !len_legal;
            mem_we  <= beat;
            rd_iss  <= issue;
            rd_smp  <= rd_iss;

            if (start_ok) begin
                base <= load_base;
                len  <= load_len;
                wcnt <= '0;
                icnt <= '0;
                scnt <= '0;
                wsum <= '0;
                rsum <= '0;
                pass <= 1'b0;
            end

            if (beat) begin
                mem_addr  <= base + wcnt[ADDR_W-1:0];
                mem_wdata <= wr_data;
                wsum      <= wsum + wr_data;
                wcnt      <= wcnt + 1'b1;
            end

            if (issue) begin
                mem_addr <= base + icnt[ADDR_W-1:0];
                icnt     <= icnt + 1'b1;
            end

            if (sample) begin
                rsum <= rsum + mem_rdata;
                scnt <= scnt + 1'b1;
            end

            // Result uses the final accumulated value so it is visible in FINISH
            if (read_last)
                pass <= ((rsum + mem_rdata) == wsum);
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a behavioural 1024x32 sync-read memory.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_start;
    logic [9:0]  load_base;
    logic [10:0] load_len;
    logic [31:0] wr_data;
    logic        wr_valid;
    logic        wr_ready;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        cpu_hold, busy, done, pass, len_err;

    imem_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .load_base  (load_base),
        .load_len   (load_len),
        .wr_data    (wr_data),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .len_err    (len_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model; corrupt flips bit 0 of address 2 on readback
    logic [31:0] mem [0:1023];
    logic        corrupt = 1'b0;
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr] ^ ((corrupt && mem_addr == 10'd2) ? 32'h1 : 32'h0);
    end

    // Write log and address history sampled mid-cycle
    int          nwe = 0;
    int          we_cyc  [0:15];
    logic [9:0]  we_addr [0:15];
    logic [31:0] we_data [0:15];
    logic [9:0]  addr_hist [0:4095];
    always @(negedge clk) begin
        addr_hist[cyc & 4095] = mem_addr;
        if (mem_we) begin
            if (nwe < 16) begin
                we_cyc[nwe]  = cyc;
                we_addr[nwe] = mem_addr;
                we_data[nwe] = mem_wdata;
            end
            nwe++;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [9:0]       base;
        logic [3:0][31:0] words;
        logic [6:0]       pat;
        logic             corrupt;
        logic             poke;
        logic             exp_pass;
    } vec_t;

    vec_t vecs [5];

    task automatic run_vec(input vec_t v);
        int         acc [4];
        int         i, p, guard, dcyc, hold_bad;
        logic       pass_at_done;
        logic [9:0] ea;
        for (int k = 0; k < 4; k++) acc[k] = 0;
        pass_at_done = 1'bx;
        @(negedge clk);
        corrupt    = v.corrupt;
        nwe        = 0;
        load_base  = v.base;
        load_len   = 11'd4;
        load_start = 1'b1;
        i = 0; p = 0; guard = 0; hold_bad = 0;
        while (i < 4 && guard < 40) begin
            @(negedge clk);
            guard++;
            if (guard == 1) begin
                load_start = 1'b0;
                check("busy_rise", {busy, cpu_hold}, 2'b11);
                check("pass_clear", pass, 1'b0);
            end
            if (v.poke && guard == 2) begin
                load_start = 1'b1;
                load_base  = 10'd500;
                load_len   = 11'd2;
            end else begin
                load_start = 1'b0;
            end
            if (!(busy && cpu_hold)) hold_bad++;
            wr_valid = (p < 7) ? v.pat[p] : 1'b1;
            p++;
            wr_data = v.words[i];
            if (wr_valid && wr_ready) begin
                acc[i] = cyc;
                i++;
            end
        end
        check("accept_count", i, 4);
        dcyc = -1;
        guard = 0;
        while (dcyc < 0 && guard < 40) begin
            @(negedge clk);
            guard++;
            wr_valid   = 1'b0;
            load_start = (v.poke && guard == 2);
            if (!(busy && cpu_hold)) hold_bad++;
            if (done) begin
                dcyc = cyc;
                pass_at_done = pass;
            end
        end
        check("done_seen", (dcyc >= 0), 1'b1);
        check("write_count", nwe, 4);
        for (int k = 0; k < 4; k++) begin
            ea = 10'(v.base + 10'(k));
            check("write_addr", we_addr[k], ea);
            check("write_data", we_data[k], v.words[k]);
            check("write_timing", we_cyc[k] - acc[k], 1);
            check("read_addr", addr_hist[(dcyc - 5 + k) & 4095], ea);
        end
        check("done_latency", dcyc - acc[3], 7);
        check("pass_at_done", pass_at_done, v.exp_pass);
        check("hold_during_load", hold_bad, 0);
        repeat (3) @(negedge clk);
        check("idle_after_done", {busy, cpu_hold, done, wr_ready}, 4'b0);
        check("pass_sticky", pass, v.exp_pass);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 1024; k++) mem[k] = 32'h0;
        vecs[0] = '{base:10'd0,    words:{32'hC169003F, 32'h0, 32'h0, 32'hE1600000},
                    pat:7'h7F,      corrupt:1'b0, poke:1'b0, exp_pass:1'b1};
        vecs[1] = '{base:10'd0,    words:{32'hC169003F, 32'h0, 32'h0, 32'hE1600000},
                    pat:7'b1011001, corrupt:1'b0, poke:1'b0, exp_pass:1'b1};
        vecs[2] = '{base:10'd1022, words:{32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111},
                    pat:7'h7F,      corrupt:1'b0, poke:1'b0, exp_pass:1'b1};
        vecs[3] = '{base:10'd10,   words:{32'h0BADF00D, 32'hCAFEBABE, 32'h12345678, 32'hA5A5A5A5},
                    pat:7'b1110101, corrupt:1'b0, poke:1'b1, exp_pass:1'b1};
        vecs[4] = '{base:10'd0,    words:{32'hFEDCBA98, 32'h76543210, 32'h89ABCDEF, 32'h01234567},
                    pat:7'h7F,      corrupt:1'b1, poke:1'b0, exp_pass:1'b0};

        rst_n = 1'b0; load_start = 1'b0; load_base = '0; load_len = '0;
        wr_data = '0; wr_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {wr_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, pass, len_err}, 64'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_outputs",
              {wr_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, pass, len_err}, 64'h0);

        for (int vi = 0; vi < 5; vi++) run_vec(vecs[vi]);

        // Illegal lengths: no load starts, pass from the corrupted load stays 0
        nwe = 0;
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            load_base  = 10'd5;
            load_len   = (j == 0) ? 11'd0 : 11'd1025;
            load_start = 1'b1;
            @(negedge clk);
            load_start = 1'b0;
            check("len_err_pulse", len_err, 1'b1);
            check("illegal_idle", {busy, cpu_hold, wr_ready}, 3'b0);
            @(negedge clk);
            check("len_err_drop", len_err, 1'b0);
        end
        check("illegal_no_write", nwe, 0);
        check("pass_sticky_illegal", pass, 1'b0);

        // Reset after two of eight beats
        @(negedge clk);
        nwe = 0; corrupt = 1'b0;
        load_base = 10'd100; load_len = 11'd8; load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0; wr_valid = 1'b1; wr_data = 32'hDEAD0000;
        @(negedge clk);
        wr_data = 32'hDEAD0001;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("reset_midload_outputs",
                 {wr_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, pass, len_err}, 64'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("reset_no_more_writes", nwe, 2);
        check("reset_stays_idle", {wr_ready, busy, cpu_hold}, 3'b0);
        wr_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
